// File: rtl/mantissa_normalizer_pkg.sv
// fp_pkg: shared FPU types and default widths
// Holds the normalizer state encoding and the default mantissa/exponent widths
// so other FPU blocks agree on them.
package fp_pkg;
  localparam int DATA_SIZE = 8;
  localparam int EXP_SIZE = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} norm_state_e;
endpackage

// File: rtl/mantissa_normalizer_if.sv
// mantissa_normalizer_if: operand/result handshake bundle for the normalizer
// Operand side: InValid/InReady, SumMantissa (MSB = carry-out), Exponent.
// Result side: OutValid/OutReady, NormMantissa, NormExponent, Overflow, Underflow, Zero.
// master drives operands and OutReady; slave is the normalizer.
interface mantissa_normalizer_if #(
  parameter int DataSize = fp_pkg::DATA_SIZE,
  parameter int ExpSize = fp_pkg::EXP_SIZE
);
  logic InValid;
  logic InReady;
  logic [DataSize:0] SumMantissa;
  logic [ExpSize-1:0] Exponent;
  logic OutValid;
  logic OutReady;
  logic [DataSize-1:0] NormMantissa;
  logic [ExpSize-1:0] NormExponent;
  logic Overflow;
  logic Underflow;
  logic Zero;
  modport master (
    output InValid, SumMantissa, Exponent, OutReady,
    input InReady, OutValid, NormMantissa, NormExponent, Overflow, Underflow, Zero
  );
  modport slave (
    input InValid, SumMantissa, Exponent, OutReady,
    output InReady, OutValid, NormMantissa, NormExponent, Overflow, Underflow, Zero
  );
endinterface

// File: rtl/mantissa_normalizer_norm_step.sv
// norm_step: one left-normalization step with underflow detect
// i_mant/i_exp: current mantissa and exponent.
// o_done: mantissa already normalized; o_underflow: not normalized and exponent is 0.
// o_mant/o_exp: mantissa shifted left by one and exponent decremented (saturating at 0).
module norm_step #(
  parameter int DataSize = fp_pkg::DATA_SIZE,
  parameter int ExpSize = fp_pkg::EXP_SIZE
) (
  input  logic [DataSize-1:0] i_mant,
  input  logic [ExpSize-1:0]  i_exp,
  output logic [DataSize-1:0] o_mant,
  output logic [ExpSize-1:0]  o_exp,
  output logic                o_done,
  output logic                o_underflow
);
  always_comb begin
    o_done = i_mant[DataSize-1];
    o_underflow = !o_done && (i_exp == '0);
    o_mant = i_mant << 1;
    o_exp = (i_exp == '0) ? '0 : i_exp - ExpSize'(1);
  end
endmodule

// File: rtl/mantissa_normalizer.sv
// mantissa_normalizer: normalizes a raw adder sum and adjusts its exponent
// Clk: rising-edge clock; RstN: asynchronous active-low reset.
// bus (slave): operand handshake in, normalized result plus Overflow/Underflow/Zero out.
// Carry and zero sums finish in one step; otherwise one left shift per SHIFT cycle.
module mantissa_normalizer #(
  parameter int DataSize = fp_pkg::DATA_SIZE,
  parameter int ExpSize = fp_pkg::EXP_SIZE
) (
  input logic Clk,
  input logic RstN,
  mantissa_normalizer_if.slave bus
);
  import fp_pkg::*;
  norm_state_e r_state;
  logic [DataSize-1:0] r_mant;
  logic [ExpSize-1:0] r_exp;
  logic r_ovf;
  logic r_unf;
  logic r_zero;
  logic [DataSize-1:0] w_step_mant;
  logic [ExpSize-1:0] w_step_exp;
  logic w_step_done;
  logic w_step_unf;
  logic [ExpSize:0] w_exp_inc;
  logic w_ovf;
  // one extra bit so an all-ones input exponent also lands in overflow instead of wrapping
  assign w_exp_inc = {1'b0, bus.Exponent} + (ExpSize+1)'(1);
  assign w_ovf = w_exp_inc >= {1'b0, {ExpSize{1'b1}}};
  norm_step #(.DataSize(DataSize), .ExpSize(ExpSize)) u_step (
    .i_mant(r_mant),
    .i_exp(r_exp),
    .o_mant(w_step_mant),
    .o_exp(w_step_exp),
    .o_done(w_step_done),
    .o_underflow(w_step_unf)
  );
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state <= IDLE;
      r_mant <= '0;
      r_exp <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.InValid) begin
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
          r_zero <= 1'b0;
          if (bus.SumMantissa[DataSize]) begin
            r_state <= DONE;
            r_ovf <= w_ovf;
            r_mant <= w_ovf ? '0 : bus.SumMantissa[DataSize:1];
            r_exp <= w_ovf ? '1 : w_exp_inc[ExpSize-1:0];
          end else if (bus.SumMantissa == '0) begin
            r_state <= DONE;
            r_zero <= 1'b1;
            r_mant <= '0;
            r_exp <= '0;
          end else begin
            r_state <= SHIFT;
            r_mant <= bus.SumMantissa[DataSize-1:0];
            r_exp <= bus.Exponent;
          end
        end
        SHIFT: if (w_step_done) begin
          r_state <= DONE;
        end else if (w_step_unf) begin
          r_state <= DONE;
          r_unf <= 1'b1;
        end else begin
          r_mant <= w_step_mant;
          r_exp <= w_step_exp;
        end
        DONE: if (bus.OutReady) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.InReady = (r_state == IDLE);
  assign bus.OutValid = (r_state == DONE);
  assign bus.NormMantissa = r_mant;
  assign bus.NormExponent = r_exp;
  assign bus.Overflow = r_ovf;
  assign bus.Underflow = r_unf;
  assign bus.Zero = r_zero;
endmodule

// File: tb/tb_mantissa_normalizer.sv
// tb_mantissa_normalizer: self-checking bench for mantissa_normalizer (DataSize=8, ExpSize=8)
module tb_mantissa_normalizer;
  logic Clk = 1'b0;
  logic RstN = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 Clk = ~Clk;
  mantissa_normalizer_if #(.DataSize(8), .ExpSize(8)) bus ();
  mantissa_normalizer #(.DataSize(8), .ExpSize(8)) dut (.Clk(Clk), .RstN(RstN), .bus(bus));
  typedef struct {
    logic [7:0] m;
    logic [7:0] x;
    logic [2:0] f;
    int lat;
  } res_t;
  // reference: flags packed {Overflow, Underflow, Zero}; lat counts sampled cycles until OutValid
  function automatic res_t model(input logic [8:0] s, input logic [7:0] e);
    res_t r;
    int v;
    int k;
    r.f = 3'b000;
    if (s == 9'd0) begin
      r.m = 8'd0; r.x = 8'd0; r.f = 3'b001; r.lat = 1;
    end else if (s >= 9'd256) begin
      r.lat = 1;
      if (int'(e) + 1 >= 255) begin
        r.m = 8'd0; r.x = 8'hff; r.f = 3'b100;
      end else begin
        r.m = 8'(int'(s) / 2); r.x = 8'(int'(e) + 1);
      end
    end else begin
      v = int'(s);
      k = 0;
      while (v < 128) begin
        v = v * 2;
        k++;
      end
      if (k <= int'(e)) begin
        r.m = 8'(v); r.x = 8'(int'(e) - k); r.lat = k + 2;
      end else begin
        r.m = 8'(int'(s) * (1 << int'(e))); r.x = 8'd0; r.f = 3'b010; r.lat = int'(e) + 2;
      end
    end
    return r;
  endfunction
  task automatic collect(output res_t o);
    o.lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge Clk);
      if (bus.OutValid === 1'b1) begin
        o.lat = i;
        break;
      end
    end
    o.m = bus.NormMantissa;
    o.x = bus.NormExponent;
    o.f = {bus.Overflow, bus.Underflow, bus.Zero};
  endtask
  task automatic send(input logic [8:0] s, input logic [7:0] e, output res_t o);
    @(negedge Clk);
    bus.InValid = 1'b1;
    bus.SumMantissa = s;
    bus.Exponent = e;
    bus.OutReady = 1'b0;
    for (int i = 0; i < 50 && bus.InReady !== 1'b1; i++) @(negedge Clk);
    @(posedge Clk);
    #1 bus.InValid = 1'b0;
    collect(o);
  endtask
  task automatic retire();
    @(negedge Clk);
    bus.OutReady = 1'b1;
    @(posedge Clk);
    #1 bus.OutReady = 1'b0;
  endtask
  task automatic test_reset();
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    bus.SumMantissa = '0;
    bus.Exponent = '0;
    #3;
    n_tests++;
    if ({bus.InReady, bus.OutValid, bus.NormMantissa, bus.NormExponent, bus.Overflow, bus.Underflow, bus.Zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b m=%h x=%h f=%b%b%b, want rdy=1 vld=0 m=00 x=00 f=000",
               bus.InReady, bus.OutValid, bus.NormMantissa, bus.NormExponent, bus.Overflow, bus.Underflow, bus.Zero);
    end
    @(negedge Clk);
    RstN = 1'b1;
  endtask
  task automatic test_directed();
    logic [8:0] d_sum [6] = '{9'b1_0110_0000, 9'b0_0001_0110, 9'b0_0000_0100, 9'b1_0000_0000, 9'd0, 9'b0_1000_0001};
    logic [7:0] d_exp [6] = '{8'd10, 8'd20, 8'd2, 8'd254, 8'd37, 8'd0};
    logic [7:0] d_m [6] = '{8'b1011_0000, 8'b1011_0000, 8'b0001_0000, 8'd0, 8'd0, 8'b1000_0001};
    logic [7:0] d_x [6] = '{8'd11, 8'd17, 8'd0, 8'd255, 8'd0, 8'd0};
    logic [2:0] d_f [6] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b000};
    int d_lat [6] = '{1, 5, 4, 1, 1, 2};
    res_t o;
    for (int i = 0; i < 6; i++) begin
      send(d_sum[i], d_exp[i], o);
      n_tests++;
      if (o.m !== d_m[i] || o.x !== d_x[i] || o.f !== d_f[i] || o.lat !== d_lat[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: got m=%h x=%0d f=%b lat=%0d, want m=%h x=%0d f=%b lat=%0d",
                 i, o.m, o.x, o.f, o.lat, d_m[i], d_x[i], d_f[i], d_lat[i]);
      end
      retire();
    end
  endtask
  task automatic test_hold();
    res_t o;
    send(9'b0_0001_0110, 8'd20, o);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      n_tests++;
      if ({bus.OutValid, bus.InReady, bus.NormMantissa, bus.NormExponent, bus.Overflow, bus.Underflow, bus.Zero} !== {1'b1, 1'b0, o.m, o.x, o.f} || o.lat < 0) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: got vld=%b rdy=%b m=%h x=%0d, want vld=1 rdy=0 m=%h x=%0d",
                 c, bus.OutValid, bus.InReady, bus.NormMantissa, bus.NormExponent, o.m, o.x);
      end
    end
    retire();
  endtask
  task automatic test_reset_mid_shift();
    res_t o;
    res_t w;
    @(negedge Clk);
    bus.InValid = 1'b1;
    bus.SumMantissa = 9'h001;
    bus.Exponent = 8'd20;
    @(posedge Clk);
    #1 bus.InValid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2 RstN = 1'b0;
    #1;
    n_tests++;
    if ({bus.OutValid, bus.InReady, bus.NormMantissa, bus.NormExponent} !== {1'b0, 1'b1, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_shift: got vld=%b rdy=%b m=%h x=%0d, want vld=0 rdy=1 m=00 x=0",
               bus.OutValid, bus.InReady, bus.NormMantissa, bus.NormExponent);
    end
    @(negedge Clk);
    RstN = 1'b1;
    send(9'h040, 8'd9, o);
    w = model(9'h040, 8'd9);
    n_tests++;
    if (o.m !== w.m || o.x !== w.x || o.f !== w.f || o.lat !== w.lat) begin
      n_fail++;
      $display("FAIL after_reset_op: got m=%h x=%0d f=%b lat=%0d, want m=%h x=%0d f=%b lat=%0d",
               o.m, o.x, o.f, o.lat, w.m, w.x, w.f, w.lat);
    end
    retire();
  endtask
  task automatic test_back_to_back();
    res_t o;
    res_t w;
    send(9'h003, 8'd100, o);
    @(negedge Clk);
    bus.InValid = 1'b1;
    bus.SumMantissa = 9'h1ff;
    bus.Exponent = 8'd40;
    bus.OutReady = 1'b1;
    @(posedge Clk);
    #1 bus.OutReady = 1'b0;
    @(negedge Clk);
    n_tests++;
    if ({bus.InReady, bus.OutValid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_no_accept_on_retire: got rdy=%b vld=%b, want rdy=1 vld=0", bus.InReady, bus.OutValid);
    end
    @(posedge Clk);
    #1 bus.InValid = 1'b0;
    collect(o);
    w = model(9'h1ff, 8'd40);
    n_tests++;
    if (o.m !== w.m || o.x !== w.x || o.f !== w.f || o.lat !== w.lat) begin
      n_fail++;
      $display("FAIL b2b_second_op: got m=%h x=%0d f=%b lat=%0d, want m=%h x=%0d f=%b lat=%0d",
               o.m, o.x, o.f, o.lat, w.m, w.x, w.f, w.lat);
    end
    retire();
  endtask
  task automatic test_random();
    res_t o;
    res_t w;
    logic [8:0] s;
    logic [7:0] e;
    int r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      s = (r == 0) ? 9'd0 : (r <= 3) ? 9'(256 + $urandom_range(0, 255)) : 9'($urandom_range(1, 255) >> $urandom_range(0, 7));
      if (r > 3 && s == 9'd0) s = 9'd1;
      r = $urandom_range(0, 2);
      e = (r == 0) ? 8'($urandom_range(0, 255)) : (r == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(250, 255));
      send(s, e, o);
      w = model(s, e);
      n_tests++;
      if (o.m !== w.m || o.x !== w.x || o.f !== w.f || o.lat !== w.lat) begin
        n_fail++;
        $display("FAIL random_%0d sum=%h exp=%0d: got m=%h x=%0d f=%b lat=%0d, want m=%h x=%0d f=%b lat=%0d",
                 i, s, e, o.m, o.x, o.f, o.lat, w.m, w.x, w.f, w.lat);
      end
      retire();
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mantissa_normalizer.md
MANTISSA_NORMALIZER -- requirements
Module: mantissa_normalizer

Interface
REQ-001 SHALL have parameter DataSize, default 8, mantissa width including hidden bit.
REQ-002 SHALL have parameter ExpSize, default 8, exponent width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Clk  input  1  clock; all state updates on rising edge.
REQ-005 RstN  input  1  asynchronous active-low reset.
REQ-006 InValid  input  1  input operand valid.
REQ-007 InReady  output  1  block can accept an operand.
REQ-008 SumMantissa  input  DataSize+1  raw adder result; MSB is carry-out.
REQ-009 Exponent  input  ExpSize  exponent of the larger operand before normalization.
REQ-010 OutValid  output  1  normalized result valid.
REQ-011 OutReady  input  1  downstream accepts result.
REQ-012 NormMantissa  output  DataSize  normalized mantissa.
REQ-013 NormExponent  output  ExpSize  adjusted exponent.
REQ-014 Overflow, Underflow, Zero  output  1 each  result flags, valid with OutValid.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 InReady SHALL equal (state == IDLE); OutValid SHALL equal (state == DONE).
REQ-017 Transfer in IDLE on InValid && InReady; operand and exponent registered that edge.
REQ-018 Carry bit set: mantissa right-shifted 1 (LSB truncated), exponent +1, go directly to DONE (latency 1).
REQ-019 Carry case where incremented exponent is all-ones: Overflow=1, NormMantissa=0, NormExponent=all-ones.
REQ-020 SumMantissa == 0: Zero=1, NormMantissa=0, NormExponent=0, go directly to DONE (latency 1).
REQ-021 Otherwise go to SHIFT; each SHIFT cycle: MSB of mantissa register set -> DONE; else if exponent == 0 -> Underflow=1, DONE; else shift left 1 (zero fill), exponent -1, stay.
REQ-022 Latency for k left shifts without underflow SHALL be k+2 cycles from accept edge to OutValid.
REQ-023 In DONE, outputs and flags SHALL hold stable while OutReady is low.
REQ-024 On OutValid && OutReady, return to IDLE; no new operand accepted in that same cycle.
REQ-025 Flags SHALL be mutually exclusive and cleared on every new accept.
REQ-026 All arithmetic unsigned; exponent decrement never wraps below 0.

Reset
REQ-027 RstN low SHALL immediately force state IDLE, InReady=1, OutValid=0, NormMantissa=0, NormExponent=0, all flags 0.
REQ-028 Reset during SHIFT or DONE SHALL discard the operation; first valid after release is a fresh operand.

Structure
REQ-029 State encodings and default DataSize/ExpSize SHALL live in shared package fp_pkg, reused by other FPU blocks.
REQ-030 One combinational sub-module norm_step SHALL perform the single-bit left shift and exponent decrement with underflow detect.
REQ-031 Expected size: 120-250 lines RTL.

Verification (DataSize=8, ExpSize=8)
REQ-032 Sum 9'b1_0110_0000, Exp 10 -> Norm 8'b1011_0000, Exp 11, no flags, OutValid 1 cycle after accept.
REQ-033 Sum 9'b0_0001_0110, Exp 20 -> Norm 8'b1011_0000, Exp 17, no flags, OutValid 5 cycles after accept.
REQ-034 Sum 9'b0_0000_0100, Exp 2 -> Norm 8'b0001_0000, Exp 0, Underflow=1, OutValid 4 cycles after accept.
REQ-035 Sum 9'b1_0000_0000, Exp 254 -> Norm 0, Exp 255, Overflow=1; Sum 0 -> Zero=1, Exp 0.
REQ-036 OutReady held low 5 cycles in DONE -> outputs stable, InReady=0; RstN pulsed low mid-SHIFT -> OutValid=0 immediately, IDLE after release.
